mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the single-port unified instruction/data memory of the multicycle core. It sits between the memory and two masters: the CPU memory path, driven by the fetch/decode controller, and the peripheral/loader port. It serialises their accesses, handles the fixed memory read latency, and returns a one-cycle acknowledge with registered read data to the winning requester.

## Interface
Parameters:
- AW, 8, word-address width
- DW, 32, data width
- LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..15

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU request, level; held until cpu_ack
- cpu_we  in  1  CPU write enable, qualified by cpu_req
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data, registered
- cpu_ack  out  1  CPU transaction complete, one-cycle pulse
- per_req, per_we, per_addr, per_wdata, per_rdata, per_ack  same widths and meaning for the peripheral port
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  a transaction is in progress (any state except IDLE)
- owner  out  1  current or last grant: 0 = CPU, 1 = peripheral

## Operation
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- States:
  - IDLE: arbitrate. If any request is high, latch the winner's we, addr and wdata, set owner, and go to ACCESS. Otherwise stay.
  - ACCESS: mem_en=1 for one cycle; mem_we equals latched we; mem_addr and mem_wdata driven from the latch. Load counter with LAT-1 and go to WAIT.
  - WAIT: decrement the counter. When the counter is 0, capture mem_rdata into the owner's rdata register (reads only), set the owner's ack register, and go to RESP.
  - RESP: owner's ack=1 for exactly this cycle; go to IDLE.
- Arbitration (default): fixed priority, CPU wins. The peripheral is served only when cpu_req=0 in IDLE.
- Handshake:
  - The requester holds req, we, addr and wdata stable until it samples ack=1.
  - It must deassert req on that same edge, so req is low in the following IDLE cycle. A req still high there starts a new transaction.
- Write transactions use the same sequence and latency. rdata is unchanged on writes.
- Each rdata register holds its value until that port's next read completion.
- A request withdrawn mid-transaction does not abort it: the transaction completes and ack still pulses.
- The other port's req is ignored while busy=1.
- mem_addr and mem_wdata hold the latched values while busy=1 and outside ACCESS. mem_en and mem_we are 0 outside ACCESS.

## Timing
- Reset: state=IDLE; mem_en, mem_we, busy, owner, cpu_ack and per_ack are 0; cpu_rdata, per_rdata, mem_addr and mem_wdata are 0; round-robin pointer favours CPU.
- Reset asserted mid-transaction aborts it immediately (asynchronously). No ack is issued and mem_en drops.
- Latency: req sampled in IDLE at cycle n. ACCESS at n+1. mem_rdata captured at n+LAT+1. ack is high at n+LAT+2.
- Total for LAT=1: 3 cycles from the first IDLE sample to ack.
- Back-to-back: minimum 1 IDLE cycle between transactions, so throughput is one access per LAT+3 cycles.
- busy is high from ACCESS through RESP inclusive.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin arbitration. A 1-bit pointer records the last owner and updates on entry to ACCESS. When both requests are high in IDLE, the port not served last wins.
- ARB_ROUND_ROBIN_EN undefined: fixed CPU priority as above, and no pointer register exists. Peripheral starvation under continuous CPU traffic is accepted behaviour.

## Test plan
- Single CPU read, LAT=1, mem word 0x05 = 0x1234_5678: cpu_req pulse-held -> mem_en high one cycle with mem_addr=0x05; cpu_ack 3 cycles after request; cpu_rdata=0x1234_5678; per_ack stays 0.
- Peripheral write addr 0x10, data 0xDEAD_BEEF, then CPU read 0x10 -> mem_we=1 only in the write's ACCESS cycle; CPU then reads 0xDEAD_BEEF; per_rdata unchanged.
- Simultaneous cpu_req and per_req held for 4 transactions:
  - without ARB_ROUND_ROBIN_EN -> grants C,C,C,C, and the peripheral is never acked;
  - with ARB_ROUND_ROBIN_EN -> grants C,P,C,P.
- LAT=4: CPU read -> ack exactly 6 cycles after the first IDLE sample; data captured from mem_rdata 4 cycles after mem_en.
- rst_n low in WAIT -> busy, mem_en and both acks are 0 immediately. After release, state is IDLE and the held cpu_req restarts the transaction from ACCESS.
- per_req dropped during WAIT -> per_ack still pulses once, and per_rdata is updated.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: CPU port, peripheral port and memory side.
// slave  : the arbiter's view (requests in, acks/rdata and memory strobes out)
// master : the surrounding system's view (requesters and memory)
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;

  logic          per_req;
  logic          per_we;
  logic [AW-1:0] per_addr;
  logic [DW-1:0] per_wdata;
  logic [DW-1:0] per_rdata;
  logic          per_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  per_req, per_we, per_addr, per_wdata,
    output per_rdata, per_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output per_req, per_we, per_addr, per_wdata,
    input  per_rdata, per_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the single-port unified memory.
// Serialises CPU and peripheral accesses, waits out the fixed read latency
// LAT (1..15) and returns a one-cycle ack with registered read data.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin arbitration on ties;
// when undefined the CPU always wins and no pointer register exists.
//
// state  | meaning
// IDLE   | arbitrate, latch the winner's request
// ACCESS | mem_en strobe for one cycle, load latency counter
// WAIT   | count down latency, capture read data at zero
// RESP   | one-cycle ack to the owner
module mem_port_arbiter #(
  parameter int AW  = 8,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus,
  output logic                busy,
  output logic                owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic          done;
  logic          grant;
  logic          grant_per;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          owner_q;
  logic          cpu_ack_q, per_ack_q;
  logic [DW-1:0] cpu_rdata_q, per_rdata_q;

  assign grant = bus.cpu_req | bus.per_req;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when the CPU was served last, so the peripheral wins the next tie;
  // cleared at reset so the CPU wins the first tie.
  logic prefer_per;

  // Pointer update on every IDLE -> ACCESS transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prefer_per <= 1'b0;
    else if (state == IDLE && grant)
      prefer_per <= ~grant_per;
  end

  assign grant_per = bus.per_req & (~bus.cpu_req | prefer_per);
`else
  assign grant_per = bus.per_req & ~bus.cpu_req;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and memory strobe decode.
  always_comb begin
    state_nxt  = state;
    done       = 1'b0;
    bus.mem_en = 1'b0;
    bus.mem_we = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (grant)
          state_nxt = ACCESS;
      end
      ACCESS: begin
        bus.mem_en = 1'b1;
        bus.mem_we = we_q;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          done      = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latency down-counter: loaded in ACCESS, terminal count at zero in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= 4'd0;
    else if (state == ACCESS)
      cnt <= CNT_LOAD;
    else if (state == WAIT && cnt != 4'd0)
      cnt <= cnt - 4'd1;
  end

  // Request latch and owner, taken from the arbitration winner in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      owner_q <= 1'b0;
    end else if (state == IDLE && grant) begin
      owner_q <= grant_per;
      if (grant_per) begin
        we_q    <= bus.per_we;
        addr_q  <= bus.per_addr;
        wdata_q <= bus.per_wdata;
      end else begin
        we_q    <= bus.cpu_we;
        addr_q  <= bus.cpu_addr;
        wdata_q <= bus.cpu_wdata;
      end
    end
  end

  // Ack pulses and per-port read data capture at the end of WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_ack_q   <= 1'b0;
      per_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      per_rdata_q <= '0;
    end else begin
      cpu_ack_q <= done & ~owner_q;
      per_ack_q <= done & owner_q;
      if (done && !we_q) begin
        if (owner_q)
          per_rdata_q <= bus.mem_rdata;
        else
          cpu_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.per_ack   = per_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.per_rdata = per_rdata_q;
  assign owner         = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: one LAT=1 instance for most scenarios and
// one LAT=4 instance for latency and mid-transaction reset scenarios.
module tb_mem_port_arbiter;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int LAT1 = 1;
  localparam int LAT4 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy1, owner1, busy4, owner4;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus4 ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1), .owner(owner1));
  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .busy(busy4), .owner(owner4));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] mem4 [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_cpu_rd, exp_per_rd;
  bit last_per;  // model: port served last (1 = peripheral, also the reset value)

  always @(posedge clk) cyc++;

  // Memory models: read data is valid only in the cycle LAT after mem_en;
  // every other cycle carries random junk.
  int rd_left1 = 0, rd_left4 = 0;
  logic [DW-1:0] rd_data1, rd_data4;
  always @(negedge clk) begin
    if (bus1.mem_en === 1'b1) begin
      if (bus1.mem_we) mem1[bus1.mem_addr] = bus1.mem_wdata;
      else begin rd_data1 = mem1[bus1.mem_addr]; rd_left1 = LAT1; end
      bus1.mem_rdata = $urandom;
    end else if (rd_left1 > 0) begin
      rd_left1--;
      bus1.mem_rdata = (rd_left1 == 0) ? rd_data1 : $urandom;
    end else bus1.mem_rdata = $urandom;
  end
  always @(negedge clk) begin
    if (bus4.mem_en === 1'b1) begin
      if (bus4.mem_we) mem4[bus4.mem_addr] = bus4.mem_wdata;
      else begin rd_data4 = mem4[bus4.mem_addr]; rd_left4 = LAT4; end
      bus4.mem_rdata = $urandom;
    end else if (rd_left4 > 0) begin
      rd_left4--;
      bus4.mem_rdata = (rd_left4 == 0) ? rd_data4 : $urandom;
    end else bus4.mem_rdata = $urandom;
  end

  task automatic apply_reset();
    bus1.cpu_req = 0; bus1.per_req = 0; bus4.cpu_req = 0; bus4.per_req = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_cpu_rd = '0; exp_per_rd = '0; last_per = 1'b1;
  endtask

  // Drives one transaction on the LAT=1 instance and reports what was seen.
  task automatic run_txn1(input bit port, input bit we, input logic [7:0] addr,
                          input logic [31:0] wdata, output int lat, output int en_cnt,
                          output int we_cnt, output logic [7:0] seen_addr,
                          output logic [31:0] seen_wdata, output bit other_ack,
                          output bit owner_bad, output logic [31:0] rdata,
                          output int ack_cyc);
    int g;
    lat = -1; en_cnt = 0; we_cnt = 0; seen_addr = '0; seen_wdata = '0;
    other_ack = 0; owner_bad = 0; rdata = '0; ack_cyc = 0; g = 0;
    @(negedge clk);
    while (busy1 && g < 50) begin @(negedge clk); g++; end
    if (!port) begin
      bus1.cpu_we = we; bus1.cpu_addr = addr; bus1.cpu_wdata = wdata; bus1.cpu_req = 1;
    end else begin
      bus1.per_we = we; bus1.per_addr = addr; bus1.per_wdata = wdata; bus1.per_req = 1;
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus1.mem_en === 1'b1) begin
        en_cnt++; seen_addr = bus1.mem_addr; seen_wdata = bus1.mem_wdata;
      end
      if (bus1.mem_we === 1'b1) we_cnt++;
      if (busy1 && owner1 !== port) owner_bad = 1;
      if ((port ? bus1.cpu_ack : bus1.per_ack) === 1'b1) other_ack = 1;
      if ((port ? bus1.per_ack : bus1.cpu_ack) === 1'b1) begin
        lat = k; ack_cyc = cyc;
        rdata = port ? bus1.per_rdata : bus1.cpu_rdata;
        break;
      end
    end
    bus1.cpu_req = 0; bus1.per_req = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({busy1, owner1, bus1.cpu_ack, bus1.per_ack, bus1.mem_en, bus1.mem_we} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 000000",
        {busy1, owner1, bus1.cpu_ack, bus1.per_ack, bus1.mem_en, bus1.mem_we});
    end
    checks++;
    if ({bus1.cpu_rdata, bus1.per_rdata} !== 64'h0) begin
      failures++; $display("FAIL reset_rdata: got %h/%h expected 0", bus1.cpu_rdata, bus1.per_rdata);
    end
    checks++;
    if ({bus1.mem_addr, bus1.mem_wdata} !== 40'h0) begin
      failures++; $display("FAIL reset_mem: got %h/%h expected 0", bus1.mem_addr, bus1.mem_wdata);
    end
    checks++;
    if ({busy4, owner4, bus4.cpu_ack, bus4.mem_en} !== 4'b0) begin
      failures++; $display("FAIL reset_dut4: got %b expected 0000",
        {busy4, owner4, bus4.cpu_ack, bus4.mem_en});
    end
  endtask

  task automatic test_single_read();
    int lat, en, wc, ac; logic [7:0] sa; logic [31:0] sw, rd; bit oa, ob;
    mem1[8'h05] = 32'h1234_5678; ref_mem[8'h05] = 32'h1234_5678;
    run_txn1(0, 0, 8'h05, 32'h0, lat, en, wc, sa, sw, oa, ob, rd, ac);
    exp_cpu_rd = ref_mem[8'h05]; last_per = 0;
    checks++;
    if (lat !== LAT1 + 2) begin failures++; $display("FAIL single_lat: got %0d expected %0d", lat, LAT1 + 2); end
    checks++;
    if (en !== 1 || sa !== 8'h05) begin
      failures++; $display("FAIL single_strobe: got en=%0d addr=%h expected en=1 addr=05", en, sa);
    end
    checks++;
    if (rd !== 32'h1234_5678) begin failures++; $display("FAIL single_rdata: got %h expected 12345678", rd); end
    checks++;
    if (oa !== 0 || ob !== 0 || wc !== 0) begin
      failures++; $display("FAIL single_side: got per_ack=%0d owner_bad=%0d we_cnt=%0d expected 0", oa, ob, wc);
    end
  endtask

  task automatic test_write_then_read();
    int lat, en, wc, ac; logic [7:0] sa; logic [31:0] sw, rd; bit oa, ob;
    run_txn1(1, 1, 8'h10, 32'hDEAD_BEEF, lat, en, wc, sa, sw, oa, ob, rd, ac);
    ref_mem[8'h10] = 32'hDEAD_BEEF; last_per = 1;
    checks++;
    if (wc !== 1 || en !== 1 || sa !== 8'h10 || sw !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL wr_strobe: got we=%0d en=%0d addr=%h data=%h expected 1 1 10 deadbeef", wc, en, sa, sw);
    end
    checks++;
    if (lat !== LAT1 + 2 || oa !== 0 || ob !== 0) begin
      failures++; $display("FAIL wr_ack: got lat=%0d cpu_ack=%0d owner_bad=%0d expected %0d 0 0", lat, oa, ob, LAT1 + 2);
    end
    checks++;
    if (bus1.per_rdata !== exp_per_rd) begin
      failures++; $display("FAIL wr_per_rdata: got %h expected %h", bus1.per_rdata, exp_per_rd);
    end
    run_txn1(0, 0, 8'h10, 32'h0, lat, en, wc, sa, sw, oa, ob, rd, ac);
    exp_cpu_rd = ref_mem[8'h10]; last_per = 0;
    checks++;
    if (rd !== 32'hDEAD_BEEF || wc !== 0) begin
      failures++; $display("FAIL rd_after_wr: got %h we=%0d expected deadbeef we=0", rd, wc);
    end
  endtask

  task automatic test_per_drop();
    int acks, en; bit dropped;
    bus1.per_we = 0; bus1.per_addr = 8'h30; bus1.per_wdata = '0;
    @(negedge clk);
    while (busy1) @(negedge clk);
    bus1.per_req = 1;
    acks = 0; en = 0; dropped = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (dropped == 0 && en == 1) begin bus1.per_req = 0; dropped = 1; end
      if (bus1.mem_en === 1'b1) en++;
      if (bus1.per_ack === 1'b1) acks++;
    end
    bus1.per_req = 0;
    exp_per_rd = ref_mem[8'h30]; last_per = 1;
    checks++;
    if (acks !== 1 || en !== 1) begin
      failures++; $display("FAIL per_drop_ack: got acks=%0d en=%0d expected 1 1", acks, en);
    end
    checks++;
    if (bus1.per_rdata !== exp_per_rd) begin
      failures++; $display("FAIL per_drop_rdata: got %h expected %h", bus1.per_rdata, exp_per_rd);
    end
  endtask

  task automatic test_back_to_back();
    int lat, en, wc, ac, prev; logic [7:0] sa; logic [31:0] sw, rd; bit oa, ob;
    prev = -1;
    for (int i = 0; i < 3; i++) begin
      run_txn1(0, 0, 8'(i + 1), 32'h0, lat, en, wc, sa, sw, oa, ob, rd, ac);
      exp_cpu_rd = ref_mem[8'(i + 1)]; last_per = 0;
      if (prev >= 0) begin
        checks++;
        if (ac - prev !== LAT1 + 3) begin
          failures++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, ac - prev, LAT1 + 3);
        end
      end
      checks++;
      if (rd !== exp_cpu_rd) begin failures++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", i, rd, exp_cpu_rd); end
      prev = ac;
    end
  endtask

  task automatic test_random();
    int lat, en, wc, ac, bad; logic [7:0] sa, a; logic [31:0] sw, rd, d; bit oa, ob, p, w;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      p = 1'($urandom); w = 1'($urandom); a = 8'($urandom_range(0, 15)); d = $urandom;
      run_txn1(p, w, a, d, lat, en, wc, sa, sw, oa, ob, rd, ac);
      last_per = p;
      if (w) ref_mem[a] = d;
      else if (p) exp_per_rd = ref_mem[a];
      else exp_cpu_rd = ref_mem[a];
      checks++;
      if (lat !== LAT1 + 2 || en !== 1 || sa !== a || wc !== int'(w) || oa || ob ||
          (w && sw !== d) || (!w && rd !== ref_mem[a])) begin
        failures++; bad++;
        $display("FAIL rand_txn[%0d]: got lat=%0d en=%0d addr=%h we=%0d wdata=%h rdata=%h oa=%0d ob=%0d expected lat=%0d addr=%h we=%0d data=%h",
          i, lat, en, sa, wc, sw, rd, oa, ob, LAT1 + 2, a, w, w ? d : ref_mem[a]);
      end
      checks++;
      if ((p ? bus1.cpu_rdata : bus1.per_rdata) !== (p ? exp_cpu_rd : exp_per_rd)) begin
        failures++; $display("FAIL rand_other_rdata[%0d]: got %h expected %h", i,
          p ? bus1.cpu_rdata : bus1.per_rdata, p ? exp_cpu_rd : exp_per_rd);
      end
    end
  endtask

  task automatic test_contention();
    int rec [4]; int n; bit exp_w; bit last;
    apply_reset();
    bus1.cpu_we = 0; bus1.cpu_addr = 8'h20; bus1.per_we = 0; bus1.per_addr = 8'h21;
    @(negedge clk);
    bus1.cpu_req = 1; bus1.per_req = 1;
    n = 0;
    for (int k = 0; k < 80 && n < 4; k++) begin
      @(negedge clk);
      if (bus1.cpu_ack === 1'b1) begin rec[n] = 0; n++; end
      else if (bus1.per_ack === 1'b1) begin rec[n] = 1; n++; end
    end
    bus1.cpu_req = 0; bus1.per_req = 0;
    checks++;
    if (n !== 4) begin failures++; $display("FAIL contention_count: got %0d expected 4", n); end
    last = last_per;
    for (int i = 0; i < n; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_w = ~last;
`else
      exp_w = 1'b0;
`endif
      last = exp_w;
      if (exp_w) exp_per_rd = ref_mem[8'h21]; else exp_cpu_rd = ref_mem[8'h20];
      checks++;
      if (rec[i] !== int'(exp_w)) begin
        failures++; $display("FAIL contention_grant[%0d]: got %0d expected %0d", i, rec[i], exp_w);
      end
    end
    last_per = last;
    @(negedge clk);
    checks++;
    if (bus1.cpu_rdata !== exp_cpu_rd || bus1.per_rdata !== exp_per_rd) begin
      failures++; $display("FAIL contention_rdata: got %h/%h expected %h/%h",
        bus1.cpu_rdata, bus1.per_rdata, exp_cpu_rd, exp_per_rd);
    end
  endtask

  task automatic test_lat4();
    int lat, en_k;
    mem4[8'h07] = 32'hA5A5_0F0F;
    @(negedge clk);
    while (busy4) @(negedge clk);
    bus4.cpu_we = 0; bus4.cpu_addr = 8'h07; bus4.cpu_req = 1;
    lat = -1; en_k = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus4.mem_en === 1'b1) en_k = k;
      if (bus4.cpu_ack === 1'b1) begin lat = k; break; end
    end
    bus4.cpu_req = 0;
    checks++;
    if (lat !== LAT4 + 2 || en_k !== 1) begin
      failures++; $display("FAIL lat4_timing: got ack=%0d en=%0d expected ack=%0d en=1", lat, en_k, LAT4 + 2);
    end
    checks++;
    if (bus4.cpu_rdata !== 32'hA5A5_0F0F) begin
      failures++; $display("FAIL lat4_rdata: got %h expected a5a50f0f", bus4.cpu_rdata);
    end
  endtask

  task automatic test_reset_wait();
    int lat, en_k, g;
    mem4[8'h09] = 32'h0BAD_F00D;
    @(negedge clk);
    while (busy4) @(negedge clk);
    bus4.cpu_we = 0; bus4.cpu_addr = 8'h09; bus4.cpu_req = 1;
    g = 0;
    @(negedge clk);
    while (bus4.mem_en !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    repeat (2) @(negedge clk);
    checks++;
    if (busy4 !== 1'b1) begin failures++; $display("FAIL rstw_busy_before: got %b expected 1", busy4); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy4, bus4.mem_en, bus4.cpu_ack, bus4.per_ack} !== 4'b0) begin
      failures++; $display("FAIL rstw_abort: got %b expected 0000", {busy4, bus4.mem_en, bus4.cpu_ack, bus4.per_ack});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cpu_rd = '0; exp_per_rd = '0; last_per = 1'b1;
    lat = -1; en_k = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus4.mem_en === 1'b1 && en_k < 0) en_k = k;
      if (bus4.cpu_ack === 1'b1) begin lat = k; break; end
    end
    bus4.cpu_req = 0;
    checks++;
    if (en_k !== 1 || lat !== LAT4 + 2 || bus4.cpu_rdata !== 32'h0BAD_F00D) begin
      failures++; $display("FAIL rstw_restart: got en=%0d ack=%0d rdata=%h expected 1 %0d 0badf00d",
        en_k, lat, bus4.cpu_rdata, LAT4 + 2);
    end
    checks++;
    if (bus1.cpu_rdata !== exp_cpu_rd) begin
      failures++; $display("FAIL rstw_dut1_rdata: got %h expected %h", bus1.cpu_rdata, exp_cpu_rd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
    bus1.per_req = 0; bus1.per_we = 0; bus1.per_addr = '0; bus1.per_wdata = '0;
    bus4.cpu_req = 0; bus4.cpu_we = 0; bus4.cpu_addr = '0; bus4.cpu_wdata = '0;
    bus4.per_req = 0; bus4.per_we = 0; bus4.per_addr = '0; bus4.per_wdata = '0;
    bus1.mem_rdata = '0; bus4.mem_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = $urandom; ref_mem[i] = mem1[i]; mem4[i] = $urandom;
    end
    test_reset();
    test_single_read();
    test_write_then_read();
    test_per_drop();
    test_back_to_back();
    test_random();
    test_contention();
    test_lat4();
    test_reset_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
